// File: rtl/alu8_cmd_issue_if.sv
`default_nettype none
// ============================================================================
// Module   : alu8_cmd_issue_if
// Brief    : Command, ALU-pin and result bundle for the ALU8 issue stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu8_cmd_issue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    // command source side
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [DATA_W-1:0]    cmd_A;
    logic [DATA_W-1:0]    cmd_B;
    logic [SEL_W-1:0]     cmd_sel;

    // ALU8 pins
    logic [DATA_W-1:0]    A;
    logic [DATA_W-1:0]    B;
    logic [SEL_W-1:0]     sel;
    logic [DATA_W-1:0]    alu_out;
    logic                 alu_Cout;

    // result consumer side
    logic                 res_valid;
    logic                 res_ready;
    logic [DATA_W-1:0]    res_out;
    logic                 res_Cout;
    logic [SEL_W-1:0]     res_sel;

    // status
    logic [c_cnt_w-1:0]   count;
    logic                 busy;

    modport slave (
        input  cmd_valid, cmd_A, cmd_B, cmd_sel, alu_out, alu_Cout, res_ready,
        output cmd_ready, A, B, sel, res_valid, res_out, res_Cout, res_sel,
        output count, busy
    );

    modport master (
        output cmd_valid, cmd_A, cmd_B, cmd_sel, alu_out, alu_Cout, res_ready,
        input  cmd_ready, A, B, sel, res_valid, res_out, res_Cout, res_sel,
        input  count, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu8_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu8_cmd_issue
// Brief    : Buffers {A,B,sel} commands, drives them onto ALU8 and captures
//            out/Cout into a valid/ready result register.
// Revision : 1.0 - initial release
// ============================================================================
module alu8_cmd_issue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu8_cmd_issue_if.slave  bus
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = 2 * DATA_W + SEL_W;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;

    logic [c_ent_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_load;
    logic               w_res_take;
    logic               w_full;

    logic [DATA_W-1:0]  w_head_a;
    logic [DATA_W-1:0]  w_head_b;
    logic [SEL_W-1:0]   w_head_sel;

    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [SEL_W-1:0]   r_sel;
    logic               r_res_valid;
    logic [DATA_W-1:0]  r_res_out;
    logic               r_res_cout;
    logic [SEL_W-1:0]   r_res_sel;

    // Ready comes from the registered count only, so a pop never frees a slot
    // for a push on the same edge.
    assign w_full = (r_count == c_full);
    assign w_push = bus.cmd_valid && !w_full;

    assign {w_head_a, w_head_b, w_head_sel} = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_res_take  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (r_count != '0) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_drive;
                end
            end
            c_st_drive: begin
                // The driven command stays at the head until its result is captured.
                w_pop       = 1'b1;
                w_state_nxt = c_st_hold;
            end
            c_st_hold: begin
                if (bus.res_ready) begin
                    w_res_take = 1'b1;
                    if (r_count != '0) begin
                        w_load      = 1'b1;
                        w_state_nxt = c_st_drive;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_A, bus.cmd_B, bus.cmd_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sel <= '0;
        end else if (w_load) begin
            r_a   <= w_head_a;
            r_b   <= w_head_b;
            r_sel <= w_head_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_out   <= '0;
            r_res_cout  <= 1'b0;
            r_res_sel   <= '0;
        end else if (w_pop) begin
            r_res_valid <= 1'b1;
            r_res_out   <= bus.alu_out;
            r_res_cout  <= bus.alu_Cout;
            r_res_sel   <= r_sel;
        end else if (w_res_take) begin
            r_res_valid <= 1'b0;
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.sel       = r_sel;
    assign bus.res_valid = r_res_valid;
    assign bus.res_out   = r_res_out;
    assign bus.res_Cout  = r_res_cout;
    assign bus.res_sel   = r_res_sel;
    assign bus.count     = r_count;
    assign bus.busy      = (r_state != c_st_idle) || (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu8_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu8_cmd_issue
// Brief    : Self-checking bench for alu8_cmd_issue with an adder stub ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu8_cmd_issue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] s;
    } cmd_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 0;

    alu8_cmd_issue_if #(.DEPTH(DEPTH), .DATA_W(8), .SEL_W(4)) bus ();

    alu8_cmd_issue #(.DEPTH(DEPTH), .DATA_W(8), .SEL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // stub ALU: plain 8-bit add with carry out
    assign {bus.alu_Cout, bus.alu_out} = {1'b0, bus.A} + {1'b0, bus.B};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: queue of accepted commands; the head is the one on the ALU
    // pins until its result has been captured.
    cmd_t       m_q[$];
    logic [7:0] m_a = 0, m_b = 0;
    logic [3:0] m_sel = 0;
    bit         m_driving = 0, m_have_res = 0, m_room = 0;
    logic [7:0] m_res_out = 0;
    logic       m_res_cout = 0;
    logic [3:0] m_res_sel = 0;
    cmd_t       m_new;

    function automatic void issue_head();
        m_a       = m_q[0].a;
        m_b       = m_q[0].b;
        m_sel     = m_q[0].s;
        m_driving = 1;
    endfunction

    always @(posedge clk) begin
        m_room = (m_q.size() < DEPTH);
        if (rst) begin
            m_q.delete();
            m_a = 0; m_b = 0; m_sel = 0;
            m_driving = 0; m_have_res = 0;
            m_res_out = 0; m_res_cout = 0; m_res_sel = 0;
        end else begin
            if (m_have_res) begin
                if (bus.res_ready) begin
                    m_have_res = 0;
                    if (m_q.size() != 0) issue_head();
                end
            end else if (m_driving) begin
                {m_res_cout, m_res_out} = {1'b0, m_q[0].a} + {1'b0, m_q[0].b};
                m_res_sel  = m_q[0].s;
                void'(m_q.pop_front());
                m_driving  = 0;
                m_have_res = 1;
            end else if (m_q.size() != 0) begin
                issue_head();
            end
            if (bus.cmd_valid && m_room) begin
                m_new = '{a: bus.cmd_A, b: bus.cmd_B, s: bus.cmd_sel};
                m_q.push_back(m_new);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_cmd_ready", 32'(bus.cmd_ready), 32'(m_q.size() < DEPTH));
            chk("m_count",     32'(bus.count),     32'(m_q.size()));
            chk("m_busy",      32'(bus.busy),      32'(m_driving || m_have_res || m_q.size() != 0));
            chk("m_A",         32'(bus.A),         32'(m_a));
            chk("m_B",         32'(bus.B),         32'(m_b));
            chk("m_sel",       32'(bus.sel),       32'(m_sel));
            chk("m_res_valid", 32'(bus.res_valid), 32'(m_have_res));
            chk("m_res_out",   32'(bus.res_out),   32'(m_res_out));
            chk("m_res_Cout",  32'(bus.res_Cout),  32'(m_res_cout));
            chk("m_res_sel",   32'(bus.res_sel),   32'(m_res_sel));
        end
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_A     = a;
        bus.cmd_B     = b;
        bus.cmd_sel   = s;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        while (!bus.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(bus.res_valid), 32'd1);
    endtask

    initial begin
        int got;
        int last;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_A = '0; bus.cmd_B = '0; bus.cmd_sel = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // single command: operands one edge after acceptance, result after two
        drive(8'h20, 8'h12, 4'h0);
        @(negedge clk);
        chk("single_A", 32'(bus.A), 32'h20);
        chk("single_B", 32'(bus.B), 32'h12);
        chk("single_sel", 32'(bus.sel), 32'h0);
        chk("single_early_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(bus.res_valid), 32'd1);
        chk("single_out", 32'(bus.res_out), 32'h32);
        chk("single_cout", 32'(bus.res_Cout), 32'd0);
        chk("single_rsel", 32'(bus.res_sel), 32'h0);
        @(negedge clk);
        chk("single_busy", 32'(bus.busy), 32'd0);

        // carry out
        drive(8'hF0, 8'h20, 4'h1);
        wait_res("carry_timeout");
        chk("carry_out", 32'(bus.res_out), 32'h10);
        chk("carry_cout", 32'(bus.res_Cout), 32'd1);
        chk("carry_rsel", 32'(bus.res_sel), 32'h1);
        @(negedge clk);

        // fill: one in flight, four queued, sixth ignored
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_A = 8'(i);
            bus.cmd_B = 8'(i);
            bus.cmd_sel = 4'(i);
            @(negedge clk);
            if (i == 5) begin
                chk("fill_count", 32'(bus.count), 32'd4);
                chk("fill_ready", 32'(bus.cmd_ready), 32'd0);
            end
        end
        bus.cmd_valid = 1'b0;
        chk("full_ignored", 32'(bus.count), 32'd4);
        bus.res_ready = 1'b1;
        got = 0;
        last = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (bus.res_valid) begin
                chk("fill_order", 32'(bus.res_out), 32'(2 * (got + 1)));
                if (got > 0) chk("fill_gap", 32'(c - last), 32'd2);
                last = c;
                got++;
            end
            @(negedge clk);
        end
        chk("fill_results", 32'(got), 32'd5);
        repeat (2) @(negedge clk);
        chk("fill_drained", 32'(bus.busy), 32'd0);

        // backpressure hold
        bus.res_ready = 1'b0;
        drive(8'h33, 8'h44, 4'h5);
        wait_res("hold_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus.res_valid), 32'd1);
            chk("hold_out", 32'(bus.res_out), 32'h77);
            chk("hold_rsel", 32'(bus.res_sel), 32'h5);
            chk("hold_A", 32'(bus.A), 32'h33);
            chk("hold_B", 32'(bus.B), 32'h44);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", 32'(bus.res_valid), 32'd0);
        chk("hold_A_kept", 32'(bus.A), 32'h33);

        // push on the same edge as the pop of the driven head
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) drive(8'(8'h10 * i), 8'h01, 4'(i));
        chk("pp_count_pre", 32'(bus.count), 32'd2);
        chk("pp_valid_pre", 32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        drive(8'h50, 8'h02, 4'h4);
        chk("pp_count", 32'(bus.count), 32'd2);
        repeat (12) @(negedge clk);
        chk("pp_drained", 32'(bus.busy), 32'd0);

        // reset mid-operation
        bus.res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive(8'(8'h40 + i), 8'h01, 4'(i));
        chk("mrst_count_pre", 32'(bus.count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_count", 32'(bus.count), 32'd0);
        chk("mrst_valid", 32'(bus.res_valid), 32'd0);
        chk("mrst_A", 32'(bus.A), 32'd0);
        chk("mrst_B", 32'(bus.B), 32'd0);
        chk("mrst_sel", 32'(bus.sel), 32'd0);
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        bus.res_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst_no_stale", 32'(bus.res_valid), 32'd0);
        end
        drive(8'h07, 8'h01, 4'h0);
        wait_res("mrst_timeout");
        chk("mrst_next", 32'(bus.res_out), 32'h08);
        @(negedge clk);

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            bus.cmd_valid = 1'($urandom_range(0, 1));
            bus.cmd_A     = 8'($urandom);
            bus.cmd_B     = 8'($urandom);
            bus.cmd_sel   = 4'($urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
